matmul_scheduler: RTL
=====================

# matmul_scheduler

Sequencer that computes a 2x2 by 2x2 unsigned matrix product through one shared 3x3-bit multiplier instance instead of four parallel ones. It latches both operand matrices on a start handshake and steps the eight partial products through the multiplier port, one per cycle. It accumulates them into four result registers, then streams the entries out under valid/ready flow control and also presents them as a parallel bus. It sits between the top-level control inputs and the existing `Multiplier` datapath module.

## Interface
- No parameters; widths fixed: element 3 bits, product 6 bits, result entry 7 bits.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `start`  in  1  request; accepted only in IDLE.
- `matrix_A`  in  12  operand A, element e = 2*row+col at bits [3e+2:3e].
- `matrix_B`  in  12  operand B, same packing.
- `mul_a`  out  3  operand to shared multiplier.
- `mul_b`  out  3  operand to shared multiplier.
- `mul_p`  in  6  combinational product of `mul_a`*`mul_b`, sampled the same cycle.
- `mul_en`  out  1  high while `mul_a`/`mul_b` carry a valid pair.
- `busy`  out  1  high in any state other than IDLE.
- `out_valid`  out  1  result entry valid.
- `out_ready`  in  1  consumer accepts entry when `out_valid` and `out_ready` are both high.
- `out_data`  out  7  current result entry.
- `out_index`  out  2  entry index, 2*row+col.
- `matrix_result`  out  28  all four entries, entry e at bits [7e+6:7e].
- `done`  out  1  one-cycle pulse after the last entry is accepted.
- `abort`  in  1  present only with `MM_SCHED_ABORT_EN`.

## Operation
- States: IDLE, MUL, OUT.
- IDLE: on `start`=1, latch `matrix_A` and `matrix_B`, clear `step`, and go to MUL. `start` is ignored in every other state.
- MUL: a 3-bit `step` s decodes as i=s[2], j=s[1], k=s[0].
  - Drive `mul_a`=A[i][k], `mul_b`=B[k][j], `mul_en`=1.
  - When k=0: C[ij] <= `mul_p` (zero-extended).
  - When k=1: C[ij] <= C[ij] + `mul_p`.
  - After s=7: go to OUT with `idx`=0.
- Arithmetic: the maximum entry is 7*7+7*7=98, so 7 bits never overflow. No saturation and no wrap occur.
- OUT:
  - `out_valid`=1, `out_data`=C[idx], `out_index`=idx.
  - On handshake, `idx` increments.
  - On handshake at idx=3: go to IDLE and pulse `done`.
  - With `out_ready` low, `out_data` and `out_index` hold stable.
- `matrix_result`:
  - Cleared when a start is accepted.
  - Updated when MUL exits.
  - Holds until the next accepted start.
- Outside MUL: `mul_a`=0, `mul_b`=0, `mul_en`=0.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `mul_en`, `out_valid`, `done` = 0.
  - `mul_a`, `mul_b`, `out_data`, `out_index`, `matrix_result` = 0.
  - Latched operands, C, `step`, `idx` = 0.
- Let edge 0 be the edge that samples `start`.
  - MUL occupies cycles 1–8.
  - `out_valid` first high in cycle 9.
  - With `out_ready` held high, entries 0–3 transfer in cycles 9–12.
  - `done` is high in cycle 13, with `busy`=0 in that cycle.
- `start` high in the same cycle as `done` is accepted, with no idle bubble.
- Minimum start-to-start spacing is 13 cycles.
- Reset asserted mid-operation forces IDLE immediately, drops `out_valid` and `busy`, and leaves no `done` pulse.
- Operand inputs may change after the start edge without effect.

## Configuration
- `MM_SCHED_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in MUL or OUT returns to IDLE on the next edge, with `busy`=0, `out_valid`=0, and no `done`.
  - `matrix_result` keeps its prior value when aborting from MUL and keeps the new value when aborting from OUT.
  - `abort` in IDLE has no effect; `abort` has priority over `start`.
- `MM_SCHED_ABORT_EN` undefined: no `abort` port, and every accepted operation runs to completion.

## Test plan
- Identity test: `matrix_A`=12'h201 (I), `matrix_B`=12'h8D1 (1,2,3,4), `out_ready`=1, start.
  - Required: entries 1,2,3,4 in cycles 9–12.
  - Required: `matrix_result`=4,3,2,1 packed.
  - Required: `done` in cycle 13.
- Mixed test: A=12'h8D1, B=12'h1F5 (5,6,7,0).
  - Required: entries 19, 6, 43, 18.
  - Required: `mul_a`/`mul_b` in cycle 1 = 1/5, in cycle 2 = 2/7.
- Max value test: A=B=12'hFFF.
  - Required: all four entries = 98.
  - Required: `matrix_result`=28'hC58B162.
- Backpressure test: mixed operands, `out_ready` low for cycles 10–12.
  - Required: `out_index`=1 and `out_data`=6 held stable.
  - Required: entry 1 transfers in cycle 13 and `done` is high in cycle 16.
- Start handling test:
  - `start` pulsed in cycle 4: required to be ignored.
  - `start` held high through `done`: required to be accepted in the `done` cycle, and the next `out_valid` rises 9 cycles later.
- Reset and abort test:
  - `reset` low in cycle 5: required `busy`=0 and all outputs 0 immediately, and no `done`.
  - With `MM_SCHED_ABORT_EN`, `abort` in cycle 10: required IDLE in cycle 11, `done` stays 0, and `matrix_result` holds the full result.

Source files
------------

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: 2x2 by 2x2 unsigned matrix product through one shared
// 3x3-bit multiplier. The eight partial products go through the multiplier
// one per cycle. The four 7-bit results then stream out under valid/ready
// flow control, and are also presented together as a parallel bus.
// Optional feature: define MM_SCHED_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | waiting for start; operands latched on an accepted start
// MUL   | step 0..7 drives one partial product per cycle into C
// OUT   | streams C[idx] out, idx 0..3, then pulses done

module matmul_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] matrix_A,
    input  logic [11:0] matrix_B,
    output logic [2:0]  mul_a,
    output logic [2:0]  mul_b,
    input  logic [5:0]  mul_p,
    output logic        mul_en,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_data,
    output logic [1:0]  out_index,
    output logic [27:0] matrix_result,
    output logic        done
`ifdef MM_SCHED_ABORT_EN
    ,
    input  logic        abort
`endif
);

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t          state, state_nxt;
    logic [11:0]     op_a, op_b;
    logic [2:0]      step;
    logic [1:0]      idx;
    logic [3:0][6:0] c_reg;
    logic [6:0]      acc;
    logic            abort_req;

`ifdef MM_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Element e = 2*row+col of a packed 2x2 matrix of 3-bit values.
    function automatic logic [2:0] elem(input logic [11:0] m, input logic [1:0] e);
        logic [2:0] v;
        case (e)
            2'd0:    v = m[2:0];
            2'd1:    v = m[5:3];
            2'd2:    v = m[8:6];
            default: v = m[11:9];
        endcase
        return v;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and outputs; step decodes as i=step[2], j=step[1], k=step[0].
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        mul_en    = 1'b0;
        mul_a     = 3'd0;
        mul_b     = 3'd0;
        out_valid = 1'b0;
        out_data  = 7'd0;
        out_index = 2'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = MUL;
            end
            MUL: begin
                mul_en = 1'b1;
                mul_a  = elem(op_a, {step[2], step[0]});
                mul_b  = elem(op_b, {step[0], step[1]});
                if (abort_req)          state_nxt = IDLE;
                else if (step == 3'd7)  state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = c_reg[idx];
                out_index = idx;
                if (abort_req)                       state_nxt = IDLE;
                else if (out_ready && idx == 2'd3)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // k=0 starts a fresh sum, k=1 adds onto it; 98 max fits in 7 bits.
    always_comb begin
        acc = (step[0] ? c_reg[step[2:1]] : 7'd0) + {1'b0, mul_p};
    end

    // Operand latch, accumulation, output index, result bus and done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_a          <= '0;
            op_b          <= '0;
            step          <= '0;
            idx           <= '0;
            c_reg         <= '0;
            matrix_result <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a          <= matrix_A;
                        op_b          <= matrix_B;
                        step          <= '0;
                        idx           <= '0;
                        matrix_result <= '0;
                    end
                end
                MUL: begin
                    if (!abort_req) begin
                        c_reg[step[2:1]] <= acc;
                        step             <= step + 3'd1;
                        if (step == 3'd7) begin
                            idx           <= '0;
                            // entry 3 is completed on this same edge, so use acc
                            matrix_result <= {acc, c_reg[2], c_reg[1], c_reg[0]};
                        end
                    end
                end
                OUT: begin
                    if (!abort_req && out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
